system_register_bank: RTL and testbench
=======================================

// Module: system_register_bank
// PURPOSE
//  Parametrised bank of NUM system registers with byte-masked writes and a registered read port.
//  Adds a save/restore context stack of DEPTH entries for exception entry/return nesting.
//  Sits in dispatch; oINFO_DATA exposes the whole bank to execute/exception logic each cycle.
// PARAMETERS
//  WIDTH        32        register width in bits; must be a multiple of 8
//  NUM          8         number of registers; AW = max(1,$clog2(NUM))
//  DEPTH        4         context stack entries; must be >= 1
//  RESET_VALUE  all 0     NUM*WIDTH bits; reg i reset value = RESET_VALUE[i*WIDTH +: WIDTH]
//  RO_MASK      all 0     NUM bits; bit i=1 -> reg i ignores iWR_* writes
//  SAVE_MASK    all 1     NUM bits; bit i=1 -> reg i is pushed/popped by iSAVE/iRESTORE
// PORTS
//  iCLOCK        in   1          sole clock, rising edge
//  iRESET_SYNC   in   1          reset, synchronous, active-high
//  iWR_VALID     in   1          write strobe
//  iWR_ADDR      in   AW         write register index
//  iWR_MASK      in   WIDTH/8    byte enables, bit b -> byte b of iWR_DATA
//  iWR_DATA      in   WIDTH      write data
//  iRD_ADDR      in   AW         read register index
//  oRD_DATA      out  WIDTH      registered read data
//  iSAVE         in   1          push SAVE_MASK regs onto context stack
//  iRESTORE      in   1          pop context stack into SAVE_MASK regs
//  oSTACK_DEPTH  out  $clog2(DEPTH+1)  entries in use
//  oSTACK_FULL   out  1          oSTACK_DEPTH == DEPTH
//  oSTACK_EMPTY  out  1          oSTACK_DEPTH == 0
//  oSTACK_ERR    out  1          sticky error flag
//  oINFO_DATA    out  NUM*WIDTH  live registers, reg i at [i*WIDTH +: WIDTH]
// BEHAVIOUR
//  Reset (iRESET_SYNC=1 at edge): regs <= RESET_VALUE; oRD_DATA <= 0; depth <= 0; oSTACK_ERR <= 0;
//   stack contents not cleared. Reset overrides every other input that cycle.
//  Write: iWR_VALID && !RO_MASK[iWR_ADDR] && iWR_ADDR<NUM -> bytes with iWR_MASK[b]=1 updated next edge;
//   other bytes hold. iWR_ADDR>=NUM or RO target: write dropped, no error.
//  Read: oRD_DATA = reg[iRD_ADDR] sampled at edge, valid 1 cycle later; iRD_ADDR>=NUM -> 0.
//  Save (iSAVE && !iRESTORE): if !full, stack[depth] <= pre-write values of SAVE_MASK regs, depth+1;
//   live regs unchanged by the save. If full: no push, depth holds, oSTACK_ERR <= 1.
//  Restore (iRESTORE && !iSAVE): if !empty, SAVE_MASK regs <= stack[depth-1], depth-1;
//   non-SAVE_MASK regs unaffected. If empty: no change, oSTACK_ERR <= 1.
//  iSAVE && iRESTORE same cycle: both ignored, depth holds, oSTACK_ERR <= 1.
//  Write + save same cycle: snapshot holds old value; write lands in live reg.
//  Write + restore same cycle: restore wins for SAVE_MASK regs; write applies to others.
//  oSTACK_ERR clears only on reset. Full/empty/depth are combinational from depth counter.
//  Depth counter never wraps: saturates at DEPTH and 0 via the error rules above.
// CONFIGURATION
//  SYSTEM_REGISTER_BANK_BYPASS_EN defined: read of iRD_ADDR == accepted iWR_ADDR in same cycle
//   returns the post-write merged value (and restore-selected value if restore targets it) in oRD_DATA.
//  Undefined: oRD_DATA returns pre-edge register contents; new value visible on the next read.
// STRUCTURE
//  Package system_register_pkg: byte_lanes(WIDTH) and addr_width(NUM) functions, byte-merge
//   function merge(old,new,mask), stack op encoding (NOP/PUSH/POP/ERR) localparams.
//  Sub-module system_register_stack: DEPTH x (NUM*WIDTH) storage, depth counter, full/empty/err;
//   inputs push/pop/push_data, output top_data. Bank, write merge and read port stay in top.
// TESTING
//  Reset with RESET_VALUE reg2=32'h0000_00FF -> oINFO_DATA reg2=0xFF, depth 0, empty=1, err=0.
//  Write reg1 0xAABBCCDD mask 4'b1111, then 0x11223344 mask 4'b0101 -> reg1 = 0xAA22CC44.
//  RO_MASK bit3=1, write reg3 0x12345678 -> reg3 keeps reset value; oRD_DATA of reg3 = reset value.
//  Write reg0=5, save, write reg0=9, restore -> reg0=5, depth 1->0; restore again -> err=1, reg0=5.
//  DEPTH=4: five saves -> depth=4, full=1, err=1 after 5th; four restores -> empty=1, err stays 1.
//  Same-cycle write reg0=7 and read reg0 (old 5): bypass build -> oRD_DATA=7; default build -> 5.

Source files
------------

// File: rtl/system_register_pkg.sv
// Shared helpers for the system register bank: sizing functions, byte-lane merge
// and the context-stack operation encoding.
package system_register_pkg;

    localparam int MERGE_W = 256;

    localparam logic [1:0] OP_NOP  = 2'd0;
    localparam logic [1:0] OP_PUSH = 2'd1;
    localparam logic [1:0] OP_POP  = 2'd2;
    localparam logic [1:0] OP_ERR  = 2'd3;

    function automatic int byte_lanes(input int width);
        return width / 8;
    endfunction

    function automatic int addr_width(input int num);
        return (num <= 2) ? 1 : $clog2(num);
    endfunction

    // Merge is sized for the widest supported register; callers cast in and out.
    function automatic logic [MERGE_W-1:0] merge(
        input logic [MERGE_W-1:0]   old_v,
        input logic [MERGE_W-1:0]   new_v,
        input logic [MERGE_W/8-1:0] mask
    );
        logic [MERGE_W-1:0] res;
        res = old_v;
        for (int b = 0; b < MERGE_W / 8; b++) begin
            if (mask[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/system_register_stack.sv
// Context stack for exception nesting: DEPTH snapshots of the register bank,
// a saturating depth counter and a sticky error flag for illegal operations.
module system_register_stack
    import system_register_pkg::*;
#(
    parameter  int DEPTH  = 4,
    parameter  int DATA_W = 256,
    localparam int DW     = $clog2(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_push_data,
    output logic [DATA_W-1:0] o_top_data,
    output logic              o_pop_fire,
    output logic [DW-1:0]     o_depth,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_err
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DW-1:0]     r_depth;
    logic              r_err;
    logic [1:0]        w_op;
    logic [DW-1:0]     w_top_idx;

    assign o_depth    = r_depth;
    assign o_full     = (r_depth == DW'(DEPTH));
    assign o_empty    = (r_depth == '0);
    assign o_err      = r_err;
    assign o_pop_fire = (w_op == OP_POP);
    assign w_top_idx  = r_depth - DW'(1);

    // NOTE: every signal driven from always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        w_op = OP_NOP;
        if (i_push && i_pop)  w_op = OP_ERR;
        else if (i_push)      w_op = o_full  ? OP_ERR : OP_PUSH;
        else if (i_pop)       w_op = o_empty ? OP_ERR : OP_POP;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_depth <= '0;
            r_err   <= 1'b0;
        end else begin
            case (w_op)
                OP_PUSH: r_depth <= r_depth + DW'(1);
                OP_POP:  r_depth <= r_depth - DW'(1);
                OP_ERR:  r_err   <= 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: snapshot storage is deliberately not reset; depth alone decides what is valid.
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_op == OP_PUSH) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_depth == DW'(i)) r_mem[i] <= i_push_data;
            end
        end
    end

    always_comb begin
        o_top_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_top_idx == DW'(i)) o_top_data = r_mem[i];
        end
    end

endmodule

// File: rtl/system_register_bank.sv
// Byte-masked system register bank with registered read port and context stack.
// Optional SYSTEM_REGISTER_BANK_BYPASS_EN forwards a same-cycle write to the read port.
module system_register_bank
    import system_register_pkg::*;
#(
    parameter  int                   WIDTH       = 32,
    parameter  int                   NUM         = 8,
    parameter  int                   DEPTH       = 4,
    parameter  logic [NUM*WIDTH-1:0] RESET_VALUE = '0,
    parameter  logic [NUM-1:0]       RO_MASK     = '0,
    parameter  logic [NUM-1:0]       SAVE_MASK   = '1,
    localparam int                   AW          = addr_width(NUM),
    localparam int                   BW          = byte_lanes(WIDTH),
    localparam int                   DW          = $clog2(DEPTH + 1)
) (
    input  logic                 iCLOCK,
    input  logic                 iRESET_SYNC,
    input  logic                 iWR_VALID,
    input  logic [AW-1:0]        iWR_ADDR,
    input  logic [BW-1:0]        iWR_MASK,
    input  logic [WIDTH-1:0]     iWR_DATA,
    input  logic [AW-1:0]        iRD_ADDR,
    output logic [WIDTH-1:0]     oRD_DATA,
    input  logic                 iSAVE,
    input  logic                 iRESTORE,
    output logic [DW-1:0]        oSTACK_DEPTH,
    output logic                 oSTACK_FULL,
    output logic                 oSTACK_EMPTY,
    output logic                 oSTACK_ERR,
    output logic [NUM*WIDTH-1:0] oINFO_DATA
);

    logic [WIDTH-1:0]     r_regs [NUM];
    logic [WIDTH-1:0]     r_rd_data;
    logic [WIDTH-1:0]     w_next [NUM];
    logic [NUM-1:0]       w_wr_hit;
    logic [WIDTH-1:0]     w_rd_sel;
    logic [NUM*WIDTH-1:0] w_top_data;
    logic                 w_pop_fire;

    system_register_stack #(
        .DEPTH  (DEPTH),
        .DATA_W (NUM * WIDTH)
    ) u_stack (
        .i_clk       (iCLOCK),
        .i_reset     (iRESET_SYNC),
        .i_push      (iSAVE),
        .i_pop       (iRESTORE),
        .i_push_data (oINFO_DATA),
        .o_top_data  (w_top_data),
        .o_pop_fire  (w_pop_fire),
        .o_depth     (oSTACK_DEPTH),
        .o_full      (oSTACK_FULL),
        .o_empty     (oSTACK_EMPTY),
        .o_err       (oSTACK_ERR)
    );

    // Restore has priority over a write for saved registers.
    always_comb begin
        for (int i = 0; i < NUM; i++) begin
            w_wr_hit[i] = iWR_VALID && (iWR_ADDR == AW'(i)) && !RO_MASK[i];
            w_next[i]   = r_regs[i];
            if (w_wr_hit[i]) begin
                w_next[i] = WIDTH'(merge(MERGE_W'(r_regs[i]), MERGE_W'(iWR_DATA),
                                         (MERGE_W/8)'(iWR_MASK)));
            end
            if (w_pop_fire && SAVE_MASK[i]) w_next[i] = w_top_data[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        w_rd_sel = '0;
        for (int i = 0; i < NUM; i++) begin
            if (iRD_ADDR == AW'(i)) begin
`ifdef SYSTEM_REGISTER_BANK_BYPASS_EN
                w_rd_sel = w_wr_hit[i] ? w_next[i] : r_regs[i];
`else
                w_rd_sel = r_regs[i];
`endif
            end
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            for (int i = 0; i < NUM; i++) r_regs[i] <= RESET_VALUE[i*WIDTH +: WIDTH];
            r_rd_data <= '0;
        end else begin
            for (int i = 0; i < NUM; i++) r_regs[i] <= w_next[i];
            r_rd_data <= w_rd_sel;
        end
    end

    assign oRD_DATA = r_rd_data;

    for (genvar g = 0; g < NUM; g++) begin : g_info
        assign oINFO_DATA[g*WIDTH +: WIDTH] = r_regs[g];
    end

endmodule

// File: tb/tb_system_register_bank.sv
// Directed bench for system_register_bank: masked writes, RO regs, context stack
// limits, same-cycle write/save/restore interactions and the read bypass option.
module tb_system_register_bank;

    localparam int WIDTH = 32;
    localparam int NUM   = 8;
    localparam int DEPTH = 4;
    localparam logic [NUM*WIDTH-1:0] RV =
        ({{(NUM*WIDTH-32){1'b0}}, 32'hDEADBEEF} << 96) |
        ({{(NUM*WIDTH-32){1'b0}}, 32'h0000_00FF} << 64);

    logic                 iCLOCK = 1'b0;
    logic                 iRESET_SYNC;
    logic                 iWR_VALID;
    logic [2:0]           iWR_ADDR;
    logic [3:0]           iWR_MASK;
    logic [WIDTH-1:0]     iWR_DATA;
    logic [2:0]           iRD_ADDR;
    logic [WIDTH-1:0]     oRD_DATA;
    logic                 iSAVE;
    logic                 iRESTORE;
    logic [2:0]           oSTACK_DEPTH;
    logic                 oSTACK_FULL;
    logic                 oSTACK_EMPTY;
    logic                 oSTACK_ERR;
    logic [NUM*WIDTH-1:0] oINFO_DATA;

    int n_checks = 0;
    int n_fail   = 0;

    system_register_bank #(
        .WIDTH       (WIDTH),
        .NUM         (NUM),
        .DEPTH       (DEPTH),
        .RESET_VALUE (RV),
        .RO_MASK     (8'h08),
        .SAVE_MASK   (8'h7F)
    ) dut (
        .iCLOCK       (iCLOCK),
        .iRESET_SYNC  (iRESET_SYNC),
        .iWR_VALID    (iWR_VALID),
        .iWR_ADDR     (iWR_ADDR),
        .iWR_MASK     (iWR_MASK),
        .iWR_DATA     (iWR_DATA),
        .iRD_ADDR     (iRD_ADDR),
        .oRD_DATA     (oRD_DATA),
        .iSAVE        (iSAVE),
        .iRESTORE     (iRESTORE),
        .oSTACK_DEPTH (oSTACK_DEPTH),
        .oSTACK_FULL  (oSTACK_FULL),
        .oSTACK_EMPTY (oSTACK_EMPTY),
        .oSTACK_ERR   (oSTACK_ERR),
        .oINFO_DATA   (oINFO_DATA)
    );

    always #5 iCLOCK = ~iCLOCK;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] get_reg(input int i);
        return oINFO_DATA[i*WIDTH +: WIDTH];
    endfunction

    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic set_write(input int a, input logic [31:0] d, input logic [3:0] m);
        iWR_VALID = 1'b1;
        iWR_ADDR  = 3'(a);
        iWR_DATA  = d;
        iWR_MASK  = m;
    endtask

    task automatic idle();
        iWR_VALID = 1'b0;
        iSAVE     = 1'b0;
        iRESTORE  = 1'b0;
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] m);
        set_write(a, d, m);
        tick();
        idle();
    endtask

    task automatic op(input logic s, input logic r);
        iSAVE    = s;
        iRESTORE = r;
        tick();
        idle();
    endtask

    task automatic do_reset();
        iRESET_SYNC = 1'b1;
        tick();
        iRESET_SYNC = 1'b0;
    endtask

    initial begin
        iRESET_SYNC = 1'b1;
        iWR_ADDR    = '0;
        iWR_DATA    = '0;
        iWR_MASK    = '0;
        iRD_ADDR    = '0;
        idle();
        tick();
        tick();
        iRESET_SYNC = 1'b0;

        check("rst_reg2", get_reg(2), 32'h0000_00FF);
        check("rst_reg3", get_reg(3), 32'hDEADBEEF);
        check("rst_reg0", get_reg(0), 32'h0);
        check("rst_depth", oSTACK_DEPTH, 3'd0);
        check("rst_empty", oSTACK_EMPTY, 1'b1);
        check("rst_full", oSTACK_FULL, 1'b0);
        check("rst_err", oSTACK_ERR, 1'b0);
        check("rst_rd", oRD_DATA, 32'h0);

        wr(1, 32'hAABBCCDD, 4'b1111);
        check("wr_full", get_reg(1), 32'hAABBCCDD);
        wr(1, 32'h11223344, 4'b0101);
        check("wr_mask", get_reg(1), 32'hAA22CC44);

        iRD_ADDR = 3'd3;
        wr(3, 32'h12345678, 4'b1111);
        check("ro_reg3", get_reg(3), 32'hDEADBEEF);
        check("ro_rd3", oRD_DATA, 32'hDEADBEEF);
        iRD_ADDR = 3'd1;
        tick();
        check("rd_reg1", oRD_DATA, 32'hAA22CC44);

        wr(0, 32'h5, 4'b1111);
        wr(7, 32'h77, 4'b1111);
        op(1'b1, 1'b0);
        check("save_depth", oSTACK_DEPTH, 3'd1);
        check("save_empty", oSTACK_EMPTY, 1'b0);
        wr(0, 32'h9, 4'b1111);
        check("reg0_9", get_reg(0), 32'h9);
        wr(7, 32'h88, 4'b1111);
        op(1'b0, 1'b1);
        check("rest_reg0", get_reg(0), 32'h5);
        check("rest_reg7_unsaved", get_reg(7), 32'h88);
        check("rest_depth", oSTACK_DEPTH, 3'd0);
        check("rest_empty", oSTACK_EMPTY, 1'b1);
        check("rest_err0", oSTACK_ERR, 1'b0);
        op(1'b0, 1'b1);
        check("underflow_err", oSTACK_ERR, 1'b1);
        check("underflow_reg0", get_reg(0), 32'h5);
        check("underflow_depth", oSTACK_DEPTH, 3'd0);

        // Reset must win over a concurrent write.
        set_write(1, 32'hFFFF_FFFF, 4'b1111);
        do_reset();
        idle();
        check("rstov_reg1", get_reg(1), 32'h0);
        check("rstov_err", oSTACK_ERR, 1'b0);

        for (int i = 0; i < 4; i++) op(1'b1, 1'b0);
        check("fill_depth", oSTACK_DEPTH, 3'd4);
        check("fill_full", oSTACK_FULL, 1'b1);
        check("fill_err0", oSTACK_ERR, 1'b0);
        op(1'b1, 1'b0);
        check("ovf_depth", oSTACK_DEPTH, 3'd4);
        check("ovf_err", oSTACK_ERR, 1'b1);
        for (int i = 0; i < 4; i++) op(1'b0, 1'b1);
        check("drain_depth", oSTACK_DEPTH, 3'd0);
        check("drain_empty", oSTACK_EMPTY, 1'b1);
        check("drain_full", oSTACK_FULL, 1'b0);
        check("drain_err", oSTACK_ERR, 1'b1);

        do_reset();
        op(1'b1, 1'b1);
        check("both_depth", oSTACK_DEPTH, 3'd0);
        check("both_err", oSTACK_ERR, 1'b1);
        do_reset();

        wr(0, 32'h5, 4'b1111);
        set_write(0, 32'hA, 4'b1111);
        op(1'b1, 1'b0);
        check("wrsave_reg0", get_reg(0), 32'hA);
        check("wrsave_depth", oSTACK_DEPTH, 3'd1);
        set_write(0, 32'hB, 4'b1111);
        op(1'b0, 1'b1);
        check("wrrest_reg0", get_reg(0), 32'h5);
        op(1'b1, 1'b0);
        set_write(7, 32'h99, 4'b1111);
        op(1'b0, 1'b1);
        check("wrrest_reg7", get_reg(7), 32'h99);
        check("wrrest_depth", oSTACK_DEPTH, 3'd0);
        check("wrrest_err", oSTACK_ERR, 1'b0);

        iRD_ADDR = 3'd0;
        wr(0, 32'h7, 4'b1111);
`ifdef SYSTEM_REGISTER_BANK_BYPASS_EN
        check("bypass_rd", oRD_DATA, 32'h7);
`else
        check("bypass_rd", oRD_DATA, 32'h5);
`endif
        check("bypass_reg0", get_reg(0), 32'h7);
        tick();
        check("rd_after", oRD_DATA, 32'h7);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
